// File: rtl/param_counter_ctrl.sv
// Parametrised up/down/bounce counter with prescaler, synchronous load,
// terminal-count pulse and a shifted output tap onto the pad bus.
module param_counter_ctrl #(
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 8,
   parameter int OUT_W      = 22,
   parameter int TAP_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [WIDTH-1:0]      limit,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [TAP_W-1:0]      tap_sel,
   output logic [WIDTH-1:0]      count,
   output logic [OUT_W-1:0]      out,
   output logic                  dir,
   output logic                  tc
);

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0]      CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]      count_q, count_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic                  dir_q, dir_d;
   logic                  tc_q, tc_d;

   mode_e mode_s;
   logic  active;
   logic  tick;
   logic  at_top;
   logic  at_zero;
   logic  limit_zero;

   assign mode_s     = mode_e'(mode);
   assign active     = en && (mode_s != MODE_HOLD);
   // The comparison uses the live prescale input, so a new reload value
   // applies on the very cycle it is presented.
   assign tick       = active && (pre_q == prescale);
   assign at_top     = (count_q >= limit);
   assign at_zero    = (count_q == '0);
   assign limit_zero = (limit == '0);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      count_d = count_q;
      pre_d   = pre_q;
      dir_d   = dir_q;
      tc_d    = 1'b0;

      if (load) begin
         count_d = load_val;
         pre_d   = '0;
      end else if (active) begin
         pre_d = tick ? '0 : (pre_q + PRE_ONE);
         if (tick) begin
            case (mode_s)
               MODE_UP: begin
                  dir_d = 1'b1;
                  if (at_top) begin
                     count_d = '0;
                     tc_d    = 1'b1;
                  end else begin
                     count_d = count_q + CNT_ONE;
                  end
               end
               MODE_DOWN: begin
                  dir_d = 1'b0;
                  if (at_zero) begin
                     count_d = limit;
                     tc_d    = 1'b1;
                  end else begin
                     count_d = count_q - CNT_ONE;
                  end
               end
               MODE_BOUNCE: begin
                  if (dir_q) begin
                     if (at_top) begin
                        dir_d   = 1'b0;
                        tc_d    = 1'b1;
                        count_d = limit_zero ? '0 : (count_q - CNT_ONE);
                     end else begin
                        count_d = count_q + CNT_ONE;
                     end
                  end else begin
                     if (at_zero) begin
                        dir_d   = 1'b1;
                        tc_d    = 1'b1;
                        count_d = limit_zero ? '0 : CNT_ONE;
                     end else begin
                        count_d = count_q - CNT_ONE;
                     end
                  end
               end
               default: begin
                  count_d = count_q;
               end
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         pre_q   <= '0;
         dir_q   <= 1'b1;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         pre_q   <= pre_d;
         dir_q   <= dir_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign dir   = dir_q;
   assign tc    = tc_q;
   // Shifting past the top of count fills with zeros, giving the blank upper bits.
   assign out   = OUT_W'(count_q >> tap_sel);

endmodule

// File: tb/tb_param_counter_ctrl.sv
// Directed self-checking bench for param_counter_ctrl with hand-computed vectors.
module tb_param_counter_ctrl;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic        load;
   logic [31:0] load_val;
   logic [31:0] limit;
   logic [7:0]  prescale;
   logic [4:0]  tap_sel;
   logic [31:0] count;
   logic [21:0] out;
   logic        dir;
   logic        tc;

   int n_cmp = 0;
   int n_err = 0;

   param_counter_ctrl #(
      .WIDTH(32), .PRESCALE_W(8), .OUT_W(22), .TAP_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
      .load_val(load_val), .limit(limit), .prescale(prescale),
      .tap_sel(tap_sel), .count(count), .out(out), .dir(dir), .tc(tc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] up_cnt [7]  = '{1, 2, 3, 4, 5, 0, 1};
      logic        up_tc  [7]  = '{0, 0, 0, 0, 0, 1, 0};
      logic [31:0] bn_cnt [8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
      logic        bn_dir [8]  = '{1, 1, 1, 0, 0, 0, 1, 1};
      logic        bn_tc  [8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
      logic [31:0] dn_cnt [9]  = '{6, 5, 4, 3, 2, 1, 0, 9, 8};
      logic        dn_tc  [9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

      rst_n = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0;
      load_val = '0; limit = '0; prescale = '0; tap_sel = '0;

      // reset state
      repeat (2) step();
      check("rst_count", count, 32'h0);
      check("rst_out", {10'b0, out}, 32'h0);
      check("rst_dir", {31'b0, dir}, 32'h1);
      check("rst_tc", {31'b0, tc}, 32'h0);
      rst_n = 1'b1;

      // asynchronous reset between edges
      load = 1'b1; load_val = 32'h1234;
      step();
      check("load_1234", count, 32'h1234);
      load = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_count", count, 32'h0);
      check("async_out", {10'b0, out}, 32'h0);
      check("async_dir", {31'b0, dir}, 32'h1);
      check("async_tc", {31'b0, tc}, 32'h0);
      #2 rst_n = 1'b1;

      // up count with wrap at limit 5
      mode = 2'b00; limit = 32'd5; prescale = 8'd0; en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check($sformatf("up_count[%0d]", i), count, up_cnt[i]);
         check($sformatf("up_tc[%0d]", i), {31'b0, tc}, {31'b0, up_tc[i]});
      end
      check("up_out_tap0", {10'b0, out}, 32'd1);

      // prescale 3 with an enable gap mid-period
      prescale = 8'd3;
      step(); check("pre_e1", count, 32'd1);
      step(); check("pre_e2", count, 32'd1);
      step(); check("pre_e3", count, 32'd1);
      step(); check("pre_e4_tick", count, 32'd2);
      step(); step();
      check("pre_mid", count, 32'd2);
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("en_off[%0d]", i), count, 32'd2);
      end
      en = 1'b1;
      step(); check("pre_resume1", count, 32'd2);
      step(); check("pre_resume2_tick", count, 32'd3);

      // bounce between 0 and 3
      prescale = 8'd0; mode = 2'b10; limit = 32'd3;
      load = 1'b1; load_val = 32'd0;
      step();
      check("bn_load", count, 32'd0);
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("bn_count[%0d]", i), count, bn_cnt[i]);
         check($sformatf("bn_dir[%0d]", i), {31'b0, dir}, {31'b0, bn_dir[i]});
         check($sformatf("bn_tc[%0d]", i), {31'b0, tc}, {31'b0, bn_tc[i]});
      end

      // load wins with en low, then count down with limit 9
      en = 1'b0; load = 1'b1; load_val = 32'd7;
      step();
      check("ld_count", count, 32'd7);
      check("ld_dir_kept", {31'b0, dir}, 32'h1);
      load = 1'b0; mode = 2'b01; limit = 32'd9; en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check($sformatf("dn_count[%0d]", i), count, dn_cnt[i]);
         check($sformatf("dn_tc[%0d]", i), {31'b0, tc}, {31'b0, dn_tc[i]});
      end
      check("dn_dir", {31'b0, dir}, 32'h0);

      // hold mode freezes count and keeps tc low
      mode = 2'b11;
      step(); step();
      check("hold_count", count, 32'd8);
      check("hold_tc", {31'b0, tc}, 32'h0);

      // limit 0 in up mode: consecutive wrapping ticks
      mode = 2'b00; limit = 32'd0;
      step();
      check("lim0_count1", count, 32'd0);
      check("lim0_tc1", {31'b0, tc}, 32'h1);
      step();
      check("lim0_tc2", {31'b0, tc}, 32'h1);

      // legacy free-running wrap at all-ones
      limit = 32'hFFFF_FFFF; load = 1'b1; load_val = 32'hFFFF_FFFE;
      step();
      load = 1'b0;
      step();
      check("free_top", count, 32'hFFFF_FFFF);
      check("free_top_tc", {31'b0, tc}, 32'h0);
      step();
      check("free_wrap", count, 32'h0);
      check("free_wrap_tc", {31'b0, tc}, 32'h1);

      // output tap window
      en = 1'b0; load = 1'b1; load_val = 32'h0010_0000;
      step();
      load = 1'b0;
      tap_sel = 5'd20; #1;
      check("tap20", {10'b0, out}, 32'h1);
      tap_sel = 5'd19; #1;
      check("tap19", {10'b0, out}, 32'h2);
      tap_sel = 5'd0; #1;
      check("tap0", {10'b0, out}, 32'h10_0000);
      tap_sel = 5'd31; #1;
      check("tap31", {10'b0, out}, 32'h0);
      load_val = 32'hFFFF_FFFF; load = 1'b1;
      step();
      load = 1'b0;
      tap_sel = 5'd0; #1;
      check("tap0_trunc", {10'b0, out}, 32'h3F_FFFF);
      tap_sel = 5'd28; #1;
      check("tap28_fill", {10'b0, out}, 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
